// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
interface pipelined_adder_if #(
  parameter int N = 32
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         c_in;
  logic         sub;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] S;
  logic         c_out;
  logic         ovf;

  // Producer of operands and consumer of results.
  modport master (
    output s_valid, A, B, c_in, sub, m_ready,
    input  s_ready, m_valid, S, c_out, ovf
  );

  // The adder itself.
  modport slave (
    input  s_valid, A, B, c_in, sub, m_ready,
    output s_ready, m_valid, S, c_out, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked carry-pipelined N-bit adder/subtractor with valid/ready
module pipelined_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  pipelined_adder_if.slave bus
);

  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;

  if (N < 1 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: N must be a positive multiple of STAGES and STAGES <= N");
  end

  // Per-stage registered state. r_a/r_b only keep the chunks still to be added;
  // r_s accumulates the sum chunks already resolved.
  logic [N-1:0] r_a [STAGES];
  logic [N-1:0] r_b [STAGES];
  logic [N-1:0] r_s [STAGES];
  logic         r_c [STAGES];
  logic         r_v [STAGES];
  logic         r_ovf;

  // Inputs feeding each stage: stage 0 sees the bus, stage k sees stage k-1.
  logic [N-1:0] w_src_a [STAGES];
  logic [N-1:0] w_src_b [STAGES];
  logic [N-1:0] w_src_s [STAGES];
  logic         w_src_c [STAGES];
  logic         w_src_v [STAGES];

  logic [W:0]   w_chunk  [STAGES];
  logic [N-1:0] w_next_a [STAGES];
  logic [N-1:0] w_next_b [STAGES];
  logic [N-1:0] w_next_s [STAGES];
  logic         w_ovf;
  logic         w_en;

  // The whole pipe moves together; it only freezes when a result is stuck at the output.
  assign w_en        = bus.m_ready || !r_v[L];
  assign bus.s_ready = w_en;
  assign bus.m_valid = r_v[L];
  assign bus.S       = r_s[L];
  assign bus.c_out   = r_c[L];
  assign bus.ovf     = r_ovf;

  // Subtraction is A + ~B + 1, so B is inverted and the carry forced high at entry.
  assign w_src_a[0] = bus.A;
  assign w_src_b[0] = bus.sub ? ~bus.B : bus.B;
  assign w_src_c[0] = bus.sub ? 1'b1 : bus.c_in;
  assign w_src_s[0] = '0;
  assign w_src_v[0] = bus.s_valid;

  for (genvar gk = 1; gk < STAGES; gk++) begin : g_link
    assign w_src_a[gk] = r_a[gk-1];
    assign w_src_b[gk] = r_b[gk-1];
    assign w_src_c[gk] = r_c[gk-1];
    assign w_src_s[gk] = r_s[gk-1];
    assign w_src_v[gk] = r_v[gk-1];
  end

  // Each stage resolves one W-bit chunk and drops the operand bits it has consumed.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k]  = {1'b0, w_src_a[k][k*W +: W]} + {1'b0, w_src_b[k][k*W +: W]}
                  + {{W{1'b0}}, w_src_c[k]};
      w_next_s[k] = w_src_s[k];
      w_next_s[k][k*W +: W] = w_chunk[k][W-1:0];
      w_next_a[k] = w_src_a[k] & ({N{1'b1}} << ((k + 1) * W));
      w_next_b[k] = w_src_b[k] & ({N{1'b1}} << ((k + 1) * W));
    end
  end

  // Carry into the MSB is recovered as sum ^ a ^ b at that bit, which also covers W=1.
  assign w_ovf = w_chunk[L][W] ^ w_chunk[L][W-1] ^ w_src_a[L][N-1] ^ w_src_b[L][N-1];

  // Pipeline registers: clear everything on reset, advance all stages on enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_next_a[k];
        r_b[k] <= w_next_b[k];
        r_s[k] <= w_next_s[k];
        r_c[k] <= w_chunk[k][W];
        r_v[k] <= w_src_v[k];
      end
      r_ovf <= w_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder in three configurations
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipelined_adder_if #(.N(16)) if0 ();
  pipelined_adder_if #(.N(8))  if1 ();
  pipelined_adder_if #(.N(8))  if2 ();

  pipelined_adder #(.N(16), .STAGES(4)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  pipelined_adder #(.N(8),  .STAGES(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  pipelined_adder #(.N(8),  .STAGES(8)) dut2 (.clk(clk), .rstn(rstn), .bus(if2));

  // Index 0: N=16/STAGES=4, 1: N=8/STAGES=1, 2: N=8/STAGES=8
  logic [15:0] d_a [3];
  logic [15:0] d_b [3];
  logic        d_v [3];
  logic        d_cin [3];
  logic        d_sub [3];
  logic        d_mr [3];
  logic [15:0] o_s [3];
  logic        o_c [3];
  logic        o_ovf [3];
  logic        o_mv [3];
  logic        o_sr [3];

  assign if0.s_valid = d_v[0];   assign if1.s_valid = d_v[1];        assign if2.s_valid = d_v[2];
  assign if0.A = d_a[0];         assign if1.A = d_a[1][7:0];         assign if2.A = d_a[2][7:0];
  assign if0.B = d_b[0];         assign if1.B = d_b[1][7:0];         assign if2.B = d_b[2][7:0];
  assign if0.c_in = d_cin[0];    assign if1.c_in = d_cin[1];         assign if2.c_in = d_cin[2];
  assign if0.sub = d_sub[0];     assign if1.sub = d_sub[1];          assign if2.sub = d_sub[2];
  assign if0.m_ready = d_mr[0];  assign if1.m_ready = d_mr[1];       assign if2.m_ready = d_mr[2];
  assign o_s[0] = if0.S;         assign o_s[1] = {8'h00, if1.S};     assign o_s[2] = {8'h00, if2.S};
  assign o_c[0] = if0.c_out;     assign o_c[1] = if1.c_out;          assign o_c[2] = if2.c_out;
  assign o_ovf[0] = if0.ovf;     assign o_ovf[1] = if1.ovf;          assign o_ovf[2] = if2.ovf;
  assign o_mv[0] = if0.m_valid;  assign o_mv[1] = if1.m_valid;       assign o_mv[2] = if2.m_valid;
  assign o_sr[0] = if0.s_ready;  assign o_sr[1] = if1.s_ready;       assign o_sr[2] = if2.s_ready;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  function automatic int width_of(input int id);
    return (id == 0) ? 16 : 8;
  endfunction

  // Arithmetic reference: unsigned result/carry and signed range check on plain integers.
  function automatic exp_t ref_op(input int n, input int a, input int b, input bit cin, input bit sub);
    exp_t e;
    int lim, half, sa, sb, r, sr;
    lim  = 1 << n;
    half = 1 << (n - 1);
    sa   = (a >= half) ? a - lim : a;
    sb   = (b >= half) ? b - lim : b;
    if (sub) begin
      r   = a - b;
      e.c = (a >= b);
      sr  = sa - sb;
    end else begin
      r   = a + b + int'(cin);
      e.c = (r >= lim);
      sr  = sa + sb + int'(cin);
    end
    e.s = 16'(r & (lim - 1));
    e.v = (sr >= half) || (sr < -half);
    return e;
  endfunction

  task automatic run_single(input int id, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub, input logic [15:0] es,
                            input logic ec, input logic eovf, input int elat, input string nm);
    int lat;
    d_a[id] = a; d_b[id] = b; d_cin[id] = cin; d_sub[id] = sub;
    d_v[id] = 1'b1; d_mr[id] = 1'b1;
    @(posedge clk); #1;
    d_v[id] = 1'b0;
    lat = 1;
    while (o_mv[id] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++; if (lat != elat) begin fails++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, elat); end
    tests++; if (o_s[id] !== es) begin fails++; $display("FAIL %s S: got %h expected %h", nm, o_s[id], es); end
    tests++; if (o_c[id] !== ec) begin fails++; $display("FAIL %s c_out: got %b expected %b", nm, o_c[id], ec); end
    tests++; if (o_ovf[id] !== eovf) begin fails++; $display("FAIL %s ovf: got %b expected %b", nm, o_ovf[id], eovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int id = 0; id < 3; id++) begin
      tests++; if (o_mv[id] !== 1'b0) begin fails++; $display("FAIL reset_m_valid[%0d]: got %b expected 0", id, o_mv[id]); end
      tests++; if (o_s[id] !== 16'h0) begin fails++; $display("FAIL reset_S[%0d]: got %h expected 0", id, o_s[id]); end
      tests++; if (o_c[id] !== 1'b0) begin fails++; $display("FAIL reset_c_out[%0d]: got %b expected 0", id, o_c[id]); end
      tests++; if (o_ovf[id] !== 1'b0) begin fails++; $display("FAIL reset_ovf[%0d]: got %b expected 0", id, o_ovf[id]); end
      tests++; if (o_sr[id] !== 1'b1) begin fails++; $display("FAIL reset_s_ready[%0d]: got %b expected 1", id, o_sr[id]); end
    end
  endtask

  task automatic test_carry_ripple();
    run_single(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "ripple");
  endtask

  task automatic test_overflow();
    run_single(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "add_ovf");
    run_single(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, "sub_ovf");
    run_single(0, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4, "sub_cin_ignored");
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, stall = 0, cyc = 0, extra = 0;
    d_b[0] = 16'h00FF; d_cin[0] = 1'b0; d_sub[0] = 1'b0;
    while (got < 6 && cyc < 60) begin
      d_v[0]  = (sent < 6);
      d_a[0]  = 16'(sent + 1);
      d_mr[0] = !(o_mv[0] === 1'b1 && stall < 3);
      #1;
      if (!d_mr[0]) begin
        tests++; if (o_sr[0] !== 1'b0) begin fails++; $display("FAIL stall_s_ready: got %b expected 0", o_sr[0]); end
        tests++;
        if (o_mv[0] !== 1'b1 || o_s[0] !== 16'h0100 || o_c[0] !== 1'b0) begin
          fails++; $display("FAIL stall_hold: got mv=%b S=%h c=%b expected mv=1 S=0100 c=0", o_mv[0], o_s[0], o_c[0]);
        end
        stall++;
      end
      if (d_v[0] && o_sr[0]) sent++;
      if (o_mv[0] && d_mr[0]) begin
        tests++;
        if (o_s[0] !== 16'h0100 + 16'(got)) begin
          fails++; $display("FAIL b2b_order: got %h expected %h", o_s[0], 16'h0100 + 16'(got));
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    d_v[0] = 1'b0; d_mr[0] = 1'b1;
    tests++; if (got != 6) begin fails++; $display("FAIL b2b_count: got %0d expected 6", got); end
    for (int i = 0; i < 8; i++) begin
      if (o_mv[0]) extra++;
      @(posedge clk); #1;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL b2b_duplicate: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    d_mr[0] = 1'b1; d_b[0] = 16'h0011; d_sub[0] = 1'b0; d_cin[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_v[0] = 1'b1;
      d_a[0] = 16'h0100 * 16'(i + 1);
      @(posedge clk); #1;
    end
    d_v[0] = 1'b0;
    tests++; if (o_mv[0] !== 1'b1 || o_s[0] !== 16'h0111) begin
      fails++; $display("FAIL midflight_pre: got mv=%b S=%h expected mv=1 S=0111", o_mv[0], o_s[0]);
    end
    #2 rstn = 1'b0;
    #1;
    tests++; if (o_mv[0] !== 1'b0) begin fails++; $display("FAIL async_reset_m_valid: got %b expected 0", o_mv[0]); end
    tests++; if (o_s[0] !== 16'h0) begin fails++; $display("FAIL async_reset_S: got %h expected 0", o_s[0]); end
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (o_mv[0]) stale++;
      @(posedge clk); #1;
    end
    tests++; if (stale != 0) begin fails++; $display("FAIL stale_after_reset: got %0d results expected 0", stale); end
    run_single(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 4, "post_reset");
  endtask

  task automatic test_narrow();
    run_single(1, 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, "n8_s1");
    run_single(2, 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8, "n8_s8");
  endtask

  task automatic test_random(input int id, input int count);
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, got = 0, cyc = 0, n;
    logic [15:0] mask;
    n    = width_of(id);
    mask = 16'((1 << n) - 1);
    while (got < count && cyc < count * 10) begin
      d_v[id]   = (sent < count) && ($urandom_range(0, 3) != 0);
      d_a[id]   = 16'($urandom) & mask;
      d_b[id]   = 16'($urandom) & mask;
      d_cin[id] = 1'($urandom_range(0, 1));
      d_sub[id] = 1'($urandom_range(0, 1));
      d_mr[id]  = ($urandom_range(0, 2) != 0);
      #1;
      if (o_mv[id] && d_mr[id]) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL random[%0d]_unexpected: got S=%h with nothing outstanding", id, o_s[id]);
        end else begin
          e = q.pop_front();
          if (o_s[id] !== e.s || o_c[id] !== e.c || o_ovf[id] !== e.v) begin
            fails++;
            $display("FAIL random[%0d]_result #%0d: got S=%h c=%b v=%b expected S=%h c=%b v=%b",
                     id, got, o_s[id], o_c[id], o_ovf[id], e.s, e.c, e.v);
          end
        end
        got++;
      end
      if (d_v[id] && o_sr[id]) begin
        q.push_back(ref_op(n, int'(d_a[id]), int'(d_b[id]), d_cin[id], d_sub[id]));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    d_v[id] = 1'b0; d_mr[id] = 1'b1;
    tests++;
    if (got != count || q.size() != 0) begin
      fails++; $display("FAIL random[%0d]_count: got %0d results, %0d pending expected %0d, 0", id, got, q.size(), count);
    end
  endtask

  initial begin
    for (int id = 0; id < 3; id++) begin
      d_a[id] = '0; d_b[id] = '0; d_v[id] = 1'b0;
      d_cin[id] = 1'b0; d_sub[id] = 1'b0; d_mr[id] = 1'b0;
    end
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    test_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int id = 0; id < 3; id++) d_mr[id] = 1'b1;
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_narrow();
    test_random(1, 1000);
    test_random(2, 1000);
    test_random(0, 500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
